// File: rtl/sp_ram_arbiter_if.sv
// Client-side bundle for sp_ram_arbiter: two req/ack command ports plus the shared busy flag.
// The arbiter takes the slave view and the requesters take the master view.
interface sp_ram_arbiter_if #(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 2
);
    logic                  req_a;
    logic                  req_b;
    logic                  we_a;
    logic                  we_b;
    logic [Addr_Width-1:0] addr_a;
    logic [Addr_Width-1:0] addr_b;
    logic [Data_Width-1:0] wdata_a;
    logic [Data_Width-1:0] wdata_b;
    logic                  ack_a;
    logic                  ack_b;
    logic [Data_Width-1:0] rdata_a;
    logic [Data_Width-1:0] rdata_b;
    logic                  busy;

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        input  ack_a, ack_b, rdata_a, rdata_b, busy
    );

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        output ack_a, ack_b, rdata_a, rdata_b, busy
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter that sequences two requesters onto one synchronous single-port RAM.
// Each command takes IDLE -> ACCESS -> WAIT, and the ack is issued in the following IDLE cycle.
module sp_ram_arbiter #(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sp_ram_arbiter_if.slave       bus,
    output logic                  ram_wr_rd_ena,
    output logic [Addr_Width-1:0] ram_addr,
    output logic [Data_Width-1:0] ram_data_write,
    input  logic [Data_Width-1:0] ram_data_read
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    state_t                state;
    state_t                state_next;
    port_t                 last;
    port_t                 cmd_port;
    port_t                 win_port;
    logic                  cmd_we;
    logic                  win_we;
    logic [Addr_Width-1:0] win_addr;
    logic [Data_Width-1:0] win_wdata;
    logic                  elig_a;
    logic                  elig_b;
    logic                  ack_a_q;
    logic                  ack_b_q;
    logic                  busy_q;
    logic [Data_Width-1:0] rdata_a_q;
    logic [Data_Width-1:0] rdata_b_q;

    // A port is blocked in its own ack cycle, so a req still high there is not served twice.
    assign elig_a = bus.req_a && !ack_a_q;
    assign elig_b = bus.req_b && !ack_b_q;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_next = state;
        win_port   = PORT_A;
        if (elig_a && elig_b) begin
            win_port = (last == PORT_B) ? PORT_A : PORT_B;
        end else if (elig_b) begin
            win_port = PORT_B;
        end

        win_we    = (win_port == PORT_B) ? bus.we_b    : bus.we_a;
        win_addr  = (win_port == PORT_B) ? bus.addr_b  : bus.addr_a;
        win_wdata = (win_port == PORT_B) ? bus.wdata_b : bus.wdata_a;

        case (state)
            IDLE:    if (elig_a || elig_b) state_next = ACCESS;
            ACCESS:  state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The RAM address/data registers double as the command registers, so they hold outside ACCESS.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state          <= IDLE;
            last           <= PORT_B;
            cmd_port       <= PORT_A;
            cmd_we         <= 1'b0;
            busy_q         <= 1'b0;
            ack_a_q        <= 1'b0;
            ack_b_q        <= 1'b0;
            rdata_a_q      <= '0;
            rdata_b_q      <= '0;
            ram_wr_rd_ena  <= 1'b0;
            ram_addr       <= '0;
            ram_data_write <= '0;
        end else begin
            state   <= state_next;
            busy_q  <= (state_next != IDLE);
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_next == ACCESS) begin
                        last           <= win_port;
                        cmd_port       <= win_port;
                        cmd_we         <= win_we;
                        ram_addr       <= win_addr;
                        ram_data_write <= win_wdata;
                        ram_wr_rd_ena  <= win_we;
                    end
                end
                ACCESS: ram_wr_rd_ena <= 1'b0;
                WAIT: begin
                    // RAM read data is valid during WAIT, one cycle after the address cycle.
                    if (cmd_port == PORT_A) begin
                        ack_a_q <= 1'b1;
                        if (!cmd_we) rdata_a_q <= ram_data_read;
                    end else begin
                        ack_b_q <= 1'b1;
                        if (!cmd_we) rdata_b_q <= ram_data_read;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ack_a   = ack_a_q;
    assign bus.ack_b   = ack_b_q;
    assign bus.rdata_a = rdata_a_q;
    assign bus.rdata_b = rdata_b_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural single-port RAM (write-enable, registered read).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sp_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       ram_wr_rd_ena;
    logic [1:0] ram_addr;
    logic [7:0] ram_data_write;
    logic [7:0] ram_data_read;
    logic [7:0] mem [4];

    int assertions = 0;
    int failures   = 0;

    sp_ram_arbiter_if #(.Data_Width(8), .Addr_Width(2)) bus ();

    sp_ram_arbiter #(.Data_Width(8), .Addr_Width(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .ram_wr_rd_ena  (ram_wr_rd_ena),
        .ram_addr       (ram_addr),
        .ram_data_write (ram_data_write),
        .ram_data_read  (ram_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        ram_data_read = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_wr_rd_ena) mem[ram_addr] <= ram_data_write;
        ram_data_read <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ack(output int cyc, output logic got_a, output logic got_b);
        cyc   = -1;
        got_a = 1'b0;
        got_b = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.ack_a || bus.ack_b) begin
                cyc   = i;
                got_a = bus.ack_a;
                got_b = bus.ack_b;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ack_a"},          32'(bus.ack_a),          32'd0);
        check({tag, " ack_b"},          32'(bus.ack_b),          32'd0);
        check({tag, " busy"},           32'(bus.busy),           32'd0);
        check({tag, " ram_wr_rd_ena"},  32'(ram_wr_rd_ena),      32'd0);
        check({tag, " rdata_a"},        32'(bus.rdata_a),        32'd0);
        check({tag, " rdata_b"},        32'(bus.rdata_b),        32'd0);
        check({tag, " ram_addr"},       32'(ram_addr),           32'd0);
        check({tag, " ram_data_write"}, 32'(ram_data_write),     32'd0);
    endtask

    // One command on one port; returns in the ack cycle with req already dropped.
    task automatic run_cmd(input string tag, input logic port_b, input logic we,
                           input logic [1:0] addr, input logic [7:0] wdata);
        int   cyc;
        logic ga;
        logic gb;
        tick();
        if (port_b) begin
            bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata; bus.req_b = 1'b1;
        end else begin
            bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata; bus.req_a = 1'b1;
        end
        wait_ack(cyc, ga, gb);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        check({tag, " latency"},  32'(cyc), 32'd3);
        check({tag, " ack port"}, {30'b0, ga, gb}, port_b ? 32'd1 : 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic ga;
        logic gb;

        // Reset held two cycles with both ports requesting.
        rst = 1'b1;
        bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 2'd0; bus.wdata_a = 8'h11;
        bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 2'd3; bus.wdata_b = 8'h22;
        tick();
        check_reset_outputs("rst c1");
        tick();
        check_reset_outputs("rst c2");
        rst = 1'b0;
        wait_ack(cyc, ga, gb);
        bus.req_a = 1'b0;
        check("post-rst first ack latency", 32'(cyc), 32'd3);
        check("post-rst first ack is A", {30'b0, ga, gb}, 32'd2);
        wait_ack(cyc, ga, gb);
        bus.req_b = 1'b0;
        check("post-rst second ack latency", 32'(cyc), 32'd3);
        check("post-rst second ack is B", {30'b0, ga, gb}, 32'd1);

        // Port A alone: write 6,5,4,3 then read them back.
        for (int i = 0; i < 4; i++) begin
            run_cmd("a write", 1'b0, 1'b1, 2'(i), 8'(6 - i));
        end
        for (int i = 0; i < 4; i++) begin
            run_cmd("a read", 1'b0, 1'b0, 2'(i), 8'h00);
            check("a read rdata_a", 32'(bus.rdata_a), 32'(6 - i));
            check("a read rdata_b untouched", 32'(bus.rdata_b), 32'd0);
        end

        // Reset during WAIT of a write: no ack, but the write already reached the RAM.
        tick();
        bus.we_a = 1'b1; bus.addr_a = 2'd2; bus.wdata_a = 8'h55; bus.req_a = 1'b1;
        tick();
        check("midrst access busy", 32'(bus.busy), 32'd1);
        check("midrst access we", 32'(ram_wr_rd_ena), 32'd1);
        check("midrst access addr", 32'(ram_addr), 32'd2);
        check("midrst access wdata", 32'(ram_data_write), 32'h55);
        tick();
        check("midrst wait busy", 32'(bus.busy), 32'd1);
        check("midrst wait we", 32'(ram_wr_rd_ena), 32'd0);
        rst = 1'b1;
        bus.req_a = 1'b0;
        tick();
        check("midrst ack_a after reset", 32'(bus.ack_a), 32'd0);
        check("midrst busy after reset", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst ack_a later", 32'(bus.ack_a), 32'd0);
        run_cmd("midrst readback", 1'b1, 1'b0, 2'd2, 8'h00);
        check("midrst readback rdata_b", 32'(bus.rdata_b), 32'h55);

        // Contention: A writes 0xAA to 1, B reads 1; both held, expect A,B,A,B.
        tick();
        bus.we_a = 1'b1; bus.addr_a = 2'd1; bus.wdata_a = 8'hAA; bus.req_a = 1'b1;
        bus.we_b = 1'b0; bus.addr_b = 2'd1; bus.req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc, ga, gb);
            check("contention latency", 32'(cyc), 32'd3);
            check("contention ack order", {30'b0, ga, gb}, (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k == 1) check("contention b reads AA", 32'(bus.rdata_b), 32'hAA);
            if (k == 2) bus.req_a = 1'b0;
            if (k == 3) bus.req_b = 1'b0;
        end

        // Held req: A keeps req one cycle past its ack -> exactly one extra command.
        tick();
        bus.we_a = 1'b0; bus.addr_a = 2'd1; bus.req_a = 1'b1;
        wait_ack(cyc, ga, gb);
        check("held first latency", 32'(cyc), 32'd3);
        check("held first ack is A", {30'b0, ga, gb}, 32'd2);
        check("held first rdata_a", 32'(bus.rdata_a), 32'hAA);
        tick();
        check("held no grant in ack cycle", 32'(bus.busy), 32'd0);
        tick();
        check("held extra grant", 32'(bus.busy), 32'd1);
        bus.req_a = 1'b0;
        wait_ack(cyc, ga, gb);
        check("held extra ack latency", 32'(cyc), 32'd2);
        check("held extra ack is A", {30'b0, ga, gb}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("held quiet busy", 32'(bus.busy), 32'd0);
            check("held quiet ack_a", 32'(bus.ack_a), 32'd0);
        end

        // A write on B must not disturb rdata_b.
        run_cmd("b read 3", 1'b1, 1'b0, 2'd3, 8'h00);
        check("b read 3 rdata_b", 32'(bus.rdata_b), 32'h03);
        run_cmd("b write 0", 1'b1, 1'b1, 2'd0, 8'h7F);
        check("b write keeps rdata_b", 32'(bus.rdata_b), 32'h03);
        tick();
        check("b write keeps rdata_b later", 32'(bus.rdata_b), 32'h03);
        run_cmd("a read 0", 1'b0, 1'b0, 2'd0, 8'h00);
        check("a read 0 sees 7F", 32'(bus.rdata_a), 32'h7F);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
